// File: rtl/sram_bus_responder.sv
// Word-organised SRAM responder for the CPU request bus: one read/write at a time,
// WAIT_CYCLES busy cycles after acceptance, then a one-cycle ack (with err on bad requests).
module sram_bus_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [31:0]       cpu_dat_i,
  input  logic [3:0]        sel_i,
  output logic [31:0]       cpu_dat_o,
  output logic              busy_o,
  output logic              ack_o,
  output logic              err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-3:0] lat_idx;
  logic [31:0]       lat_dat;
  logic [3:0]        lat_sel;
  logic              lat_rd, lat_wr;
  logic              err_q;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              commit;
  logic [ADDR_W-3:0] c_idx;
  logic [31:0]       c_dat;
  logic [3:0]        c_sel;
  logic              c_rd, c_wr, c_oor, c_err, c_do_wr, c_do_rd;
  logic [AW-1:0]     c_word;

  assign accept = (state == IDLE) && (read_i || write_i);

  // With no wait states the commit edge is the acceptance edge, so the live inputs are used.
  always_comb begin
    c_idx  = lat_idx;
    c_dat  = lat_dat;
    c_sel  = lat_sel;
    c_rd   = lat_rd;
    c_wr   = lat_wr;
    commit = (state == WAIT) && (cnt == '0);
    if (WAIT_CYCLES == 0) begin
      c_idx  = adr_i[ADDR_W-1:2];
      c_dat  = cpu_dat_i;
      c_sel  = sel_i;
      c_rd   = read_i;
      c_wr   = write_i;
      commit = accept;
    end
  end

  assign c_word  = c_idx[AW-1:0];
  assign c_oor   = (c_idx >> AW) != '0;
  assign c_err   = (c_rd && c_wr) || c_oor;
  assign c_do_wr = commit && c_wr && !c_rd && !c_oor;
  assign c_do_rd = commit && c_rd && !c_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? DONE : WAIT;
      WAIT: if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == WAIT);
    ack_o  = (state == DONE);
    err_o  = (state == DONE) && err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lat_idx   <= '0;
      lat_dat   <= '0;
      lat_sel   <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      err_q     <= 1'b0;
      cpu_dat_o <= '0;
    end else begin
      if (accept) begin
        cnt     <= CW'(WAIT_CYCLES - 1);
        lat_idx <= adr_i[ADDR_W-1:2];
        lat_dat <= cpu_dat_i;
        lat_sel <= sel_i;
        lat_rd  <= read_i;
        lat_wr  <= write_i;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) err_q <= c_err;
      if (c_do_rd) cpu_dat_o <= c_oor ? 32'h0 : mem[c_word];
    end
  end

  // Array is never reset; an aborted transaction must not reach it.
  always_ff @(posedge clk) begin
    if (!rst && c_do_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (c_sel[b]) mem[c_word][8*b +: 8] <= c_dat[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/sram_bus_responder.md
Name: sram_bus_responder

Overview:
Memory-side responder for the CPU request bus (read_i/write_i/adr_i/cpu_dat_i/sel_i in; busy_o/cpu_dat_o out). It services one read or write at a time from an internal word-organised SRAM model, with a programmable wait-state count. It sits between the request unit and on-chip data/instruction storage. It also serves as the bench-side memory model for request unit verification.

Parameters:
ADDR_W, 32, width of adr_i (byte address)
DEPTH, 256, number of 32-bit words in the array (power of two)
WAIT_CYCLES, 2, busy cycles between request acceptance and completion (0 legal)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous reset, active-high
read_i  input  1  read request, level, held by initiator
write_i  input  1  write request, level, held by initiator
adr_i  input  ADDR_W  byte address; bits [1:0] ignored
cpu_dat_i  input  32  write data
sel_i  input  4  byte-lane enables for writes; bit n = bits [8n+7:8n]
cpu_dat_o  output  32  read data
busy_o  output  1  transaction in progress
ack_o  output  1  one-cycle completion pulse
err_o  output  1  one-cycle error pulse, coincident with ack_o

Behaviour:
- Reset (async, rst=1): state=IDLE; busy_o=0, ack_o=0, err_o=0, cpu_dat_o=0. Memory array is not cleared; its contents are undefined until written.
- States: IDLE, WAIT, DONE.
- IDLE:
  - busy_o=0.
  - If read_i|write_i is high at a rising edge, the request is accepted. The responder latches adr_i, cpu_dat_i, sel_i and op.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise DONE.
- WAIT:
  - busy_o=1. A counter loads WAIT_CYCLES-1 and decrements each cycle; at 0, next state is DONE.
  - Input changes during WAIT are ignored; only the latched values are used.
- Commit: the write or read happens on the edge entering DONE.
  - Write: for each sel bit set, the corresponding byte lane of mem[word index] is updated. sel=0 writes nothing but still completes.
  - Read: cpu_dat_o <= mem[word index] (full word, sel ignored).
- DONE: busy_o=0, ack_o=1 for exactly one cycle, then unconditional return to IDLE.
- Latency: request sampled at edge k. busy_o is high for cycles k+1..k+WAIT_CYCLES. ack_o is high in cycle k+WAIT_CYCLES+1.
- cpu_dat_o holds the last read result until the next read commits. Writes never change cpu_dat_o.
- A request still held in IDLE after DONE is accepted again as a new transaction. The initiator drops its request on ack_o.
- Word index is adr_i[ADDR_W-1:2].
  - Out of range (index >= DEPTH): no array access, cpu_dat_o <= 0 on a read, err_o=1 with ack_o.
- read_i and write_i both high at acceptance is illegal: no array access, cpu_dat_o unchanged, err_o=1 with ack_o, normal latency.
- Reset mid-transaction (WAIT or DONE): the transaction is aborted and a pending write is discarded. Outputs take reset values immediately; the array keeps its prior contents.

Test Plan:
- WAIT_CYCLES=2: write adr=0x10, dat=0xCAFEBABE, sel=0xF, then read adr=0x10 -> busy_o high for exactly 2 cycles, ack_o in 3rd cycle after acceptance, cpu_dat_o=0xCAFEBABE, err_o=0.
- Byte lanes: write 0x11223344 sel=0xF to adr 0x20, then write 0xAABBCCDD sel=0x5 -> read returns 0x11BB33DD; a write with sel=0 leaves it unchanged, still acks.
- WAIT_CYCLES=0 build: read held continuously -> ack_o every 2nd cycle, busy_o never high, back-to-back transactions each return correct data.
- Out of range, DEPTH=256: read adr=0x400 -> ack_o=1, err_o=1, cpu_dat_o=0. Write adr=0x400 -> err_o=1 and word 0 is unaffected (read adr 0x0 returns its prior value).
- Illegal op: read_i=write_i=1 at adr 0x10 -> err_o=1 with ack_o, mem[4] and cpu_dat_o unchanged.
- Reset mid-write: accept write 0xDEADBEEF to adr 0x30, assert rst during WAIT -> busy_o=0, ack_o=0 immediately. A subsequent read of 0x30 returns the pre-write value.
